// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multicycle CPU control unit:
// state codes, opcode map, ALU function codes and datapath mux selects.
package cpu_ctrl_pkg;

    // Controller states; the numeric code is exported on the State debug port
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        ALU_WB   = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WB   = 4'd7,
        MEM_WR   = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        JAL1     = 4'd11,
        JAL2     = 4'd12,
        HALT     = 4'd13
    } state_e;

    // Single-opcode instructions (R, I and branch are ranges, see helpers)
    localparam logic [5:0] OP_LUI  = 6'h1F;
    localparam logic [5:0] OP_LW   = 6'h20;
    localparam logic [5:0] OP_SW   = 6'h21;
    localparam logic [5:0] OP_J    = 6'h38;
    localparam logic [5:0] OP_JAL  = 6'h39;
    localparam logic [5:0] OP_HALT = 6'h3F;

    // ALU function codes
    localparam logic [3:0] ALU_ADD    = 4'h0;
    localparam logic [3:0] ALU_SUB    = 4'h1;
    localparam logic [3:0] ALU_AND    = 4'h2;
    localparam logic [3:0] ALU_OR     = 4'h3;
    localparam logic [3:0] ALU_XOR    = 4'h4;
    localparam logic [3:0] ALU_NOR    = 4'h5;
    localparam logic [3:0] ALU_SLT    = 4'h6;
    localparam logic [3:0] ALU_SLL    = 4'h7;
    localparam logic [3:0] ALU_SRL    = 4'h8;
    localparam logic [3:0] ALU_PASS_A = 4'hF;

    // Immediate extension select
    localparam logic [1:0] SZS_SEXT = 2'b00;
    localparam logic [1:0] SZS_ZEXT = 2'b01;
    localparam logic [1:0] SZS_HI16 = 2'b10;

    // Register-file write destination select
    localparam logic [1:0] REGDST_RD1 = 2'b00;
    localparam logic [1:0] REGDST_RD3 = 2'b01;
    localparam logic [1:0] REGDST_R31 = 2'b10;

    // ALU A operand select
    localparam logic [2:0] ASA_PC   = 3'b000;
    localparam logic [2:0] ASA_A    = 3'b001;
    localparam logic [2:0] ASA_ZERO = 3'b010;

    // ALU B operand select
    localparam logic [1:0] ASB_B   = 2'b00;
    localparam logic [1:0] ASB_ONE = 2'b01;
    localparam logic [1:0] ASB_IMM = 2'b10;

    // PC source select
    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    // Full control word driven into the datapath each cycle
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       mem_write;
        logic       mdr_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       reg_read;
        logic [1:0] pc_source;
        logic [1:0] alu_src_b;
        logic [1:0] szs;
        logic [1:0] branch_cond;
        logic [1:0] reg_dst;
        logic [2:0] alu_src_a;
        logic [3:0] alu_op;
        logic       halted;
        logic       illegal_op;
    } ctrl_t;

    // R-type: 0x00..0x08
    function automatic logic is_rtype(input logic [5:0] op);
        return (op[5:4] == 2'b00) && (op[3:0] <= 4'd8);
    endfunction

    // I-type ALU: 0x10..0x18 (LUI is handled separately)
    function automatic logic is_itype(input logic [5:0] op);
        return (op[5:4] == 2'b01) && (op[3:0] <= 4'd8);
    endfunction

    // Logical immediates (AND/OR/XOR/NOR) take a zero-extended immediate
    function automatic logic is_logic_imm(input logic [5:0] op);
        return (op[5:4] == 2'b01) && (op[3:0] >= 4'd2) && (op[3:0] <= 4'd5);
    endfunction

    // Branches: 0x30..0x33
    function automatic logic is_branch(input logic [5:0] op);
        return op[5:2] == 4'b1100;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode of controller state plus opcode into the datapath
// control word and the next state.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  state_e      state_i,
    input  logic [5:0]  opcode_i,
    input  logic        run_i,
    output ctrl_t       ctrl_o,
    output state_e      next_o
);

    // Moore decode: every field defaults to 0, each state raises its own strobes
    always_comb begin
        ctrl_o = '0;
        next_o = state_i;
        case (state_i)
            FETCH: begin
                if (run_i) begin
                    ctrl_o.ir_write  = 1'b1;
                    ctrl_o.alu_src_a = ASA_PC;
                    ctrl_o.alu_src_b = ASB_ONE;
                    ctrl_o.alu_op    = ALU_ADD;
                    ctrl_o.pc_source = PCS_ALU;
                    ctrl_o.pc_write  = 1'b1;
                    next_o           = DECODE;
                end
            end
            DECODE: begin
                // Precompute branch target PC+1+simm while the opcode is decoded
                ctrl_o.alu_src_a = ASA_PC;
                ctrl_o.alu_src_b = ASB_IMM;
                ctrl_o.szs       = SZS_SEXT;
                ctrl_o.alu_op    = ALU_ADD;
                if (is_rtype(opcode_i)) begin
                    next_o = EXEC_R;
                end else if (is_itype(opcode_i) || opcode_i == OP_LUI) begin
                    next_o = EXEC_I;
                end else if (opcode_i == OP_LW || opcode_i == OP_SW) begin
                    next_o = MEM_ADDR;
                end else if (is_branch(opcode_i)) begin
                    next_o = BRANCH;
                end else if (opcode_i == OP_J) begin
                    next_o = JUMP;
                end else if (opcode_i == OP_JAL) begin
                    next_o = JAL1;
                end else if (opcode_i == OP_HALT) begin
                    next_o = HALT;
                end else begin
                    ctrl_o.illegal_op = 1'b1;
                    next_o            = FETCH;
                end
            end
            EXEC_R: begin
                ctrl_o.reg_read  = 1'b1;
                ctrl_o.alu_src_a = ASA_A;
                ctrl_o.alu_src_b = ASB_B;
                ctrl_o.alu_op    = opcode_i[3:0];
                next_o           = ALU_WB;
            end
            EXEC_I: begin
                ctrl_o.alu_src_b = ASB_IMM;
                if (opcode_i == OP_LUI) begin
                    ctrl_o.alu_src_a = ASA_ZERO;
                    ctrl_o.szs       = SZS_HI16;
                    ctrl_o.alu_op    = ALU_ADD;
                end else begin
                    ctrl_o.alu_src_a = ASA_A;
                    ctrl_o.szs       = is_logic_imm(opcode_i) ? SZS_ZEXT : SZS_SEXT;
                    ctrl_o.alu_op    = opcode_i[3:0];
                end
                next_o = ALU_WB;
            end
            ALU_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b0;
                ctrl_o.reg_dst    = is_rtype(opcode_i) ? REGDST_RD3 : REGDST_RD1;
                next_o            = FETCH;
            end
            MEM_ADDR: begin
                ctrl_o.alu_src_a = ASA_A;
                ctrl_o.alu_src_b = ASB_IMM;
                ctrl_o.szs       = SZS_SEXT;
                ctrl_o.alu_op    = ALU_ADD;
                next_o           = (opcode_i == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                ctrl_o.mdr_write = 1'b1;
                next_o           = MEM_WB;
            end
            MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_dst    = REGDST_RD1;
                next_o            = FETCH;
            end
            MEM_WR: begin
                ctrl_o.mem_write = 1'b1;
                next_o           = FETCH;
            end
            BRANCH: begin
                ctrl_o.alu_src_a     = ASA_A;
                ctrl_o.alu_src_b     = ASB_B;
                ctrl_o.alu_op        = ALU_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCS_ALUOUT;
                ctrl_o.branch_cond   = opcode_i[1:0];
                next_o               = FETCH;
            end
            JUMP: begin
                ctrl_o.pc_source = PCS_JUMP;
                ctrl_o.pc_write  = 1'b1;
                next_o           = FETCH;
            end
            JAL1: begin
                // ALU passes the already-incremented PC through for the link write
                ctrl_o.alu_src_a = ASA_PC;
                ctrl_o.alu_op    = ALU_PASS_A;
                ctrl_o.pc_source = PCS_JUMP;
                ctrl_o.pc_write  = 1'b1;
                next_o           = JAL2;
            end
            JAL2: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = REGDST_R31;
                ctrl_o.mem_to_reg = 1'b0;
                next_o            = FETCH;
            end
            HALT: begin
                ctrl_o.halted = 1'b1;
                next_o        = HALT;
            end
            default: begin
                next_o = FETCH;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control unit: state register and retired-instruction
// counter around the combinational control decoder.
module multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Run,
    input  logic [5:0]           OPCODE,
    output logic                 PCWrite,
    output logic                 PCWriteCond,
    output logic                 IRWrite,
    output logic                 MemWrite,
    output logic                 MDRWrite,
    output logic                 RegWrite,
    output logic                 MemtoReg,
    output logic                 RegRead,
    output logic [1:0]           PCSource,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           SZS,
    output logic [1:0]           BranchCond,
    output logic [1:0]           RegDst,
    output logic [2:0]           ALUSrcA,
    output logic [3:0]           ALUOp,
    output logic                 Halted,
    output logic                 IllegalOp,
    output logic [CNT_WIDTH-1:0] RetireCnt,
    output logic [3:0]           State
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_e                state_q;
    state_e                state_d;
    logic [CNT_WIDTH-1:0]  retire_q;
    logic [CNT_WIDTH-1:0]  retire_d;
    logic                  retire_evt;
    ctrl_t                 ctrl;

    // Reset also gates Run so FETCH shows no strobes while reset is held
    ctrl_decode u_decode (
        .state_i  (state_q),
        .opcode_i (OPCODE),
        .run_i    (Run & ~Reset),
        .ctrl_o   (ctrl),
        .next_o   (state_d)
    );

    // An instruction retires on any return to FETCH and on entering HALT
    always_comb begin
        retire_evt = ((state_q != FETCH) && (state_d == FETCH)) ||
                     ((state_q != HALT)  && (state_d == HALT));
        retire_d   = retire_evt ? (retire_q + CNT_ONE) : retire_q;
    end

    // State and retire counter; async reset abandons any in-flight instruction
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= FETCH;
            retire_q <= '0;
        end else begin
            state_q  <= state_d;
            retire_q <= retire_d;
        end
    end

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IRWrite     = ctrl.ir_write;
    assign MemWrite    = ctrl.mem_write;
    assign MDRWrite    = ctrl.mdr_write;
    assign RegWrite    = ctrl.reg_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegRead     = ctrl.reg_read;
    assign PCSource    = ctrl.pc_source;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign SZS         = ctrl.szs;
    assign BranchCond  = ctrl.branch_cond;
    assign RegDst      = ctrl.reg_dst;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUOp       = ctrl.alu_op;
    assign Halted      = ctrl.halted;
    assign IllegalOp   = ctrl.illegal_op;
    assign RetireCnt   = retire_q;
    assign State       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks R, LW, branch, JAL, I-type,
// illegal, Run gating, mid-instruction reset and HALT.
module tb_multicycle_control;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Run;
    logic [5:0]  OPCODE;
    logic        PCWrite, PCWriteCond, IRWrite, MemWrite, MDRWrite;
    logic        RegWrite, MemtoReg, RegRead;
    logic [1:0]  PCSource, ALUSrcB, SZS, BranchCond, RegDst;
    logic [2:0]  ALUSrcA;
    logic [3:0]  ALUOp;
    logic        Halted, IllegalOp;
    logic [31:0] RetireCnt;
    logic [3:0]  State;

    int checks = 0;
    int errors = 0;

    multicycle_control #(.CNT_WIDTH(32)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .OPCODE(OPCODE),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IRWrite(IRWrite),
        .MemWrite(MemWrite), .MDRWrite(MDRWrite), .RegWrite(RegWrite),
        .MemtoReg(MemtoReg), .RegRead(RegRead), .PCSource(PCSource),
        .ALUSrcB(ALUSrcB), .SZS(SZS), .BranchCond(BranchCond), .RegDst(RegDst),
        .ALUSrcA(ALUSrcA), .ALUOp(ALUOp), .Halted(Halted), .IllegalOp(IllegalOp),
        .RetireCnt(RetireCnt), .State(State)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clk);
    endtask

    initial begin
        Reset = 1'b1; Run = 1'b1; OPCODE = 6'h00;
        repeat (3) tick();
        #1;
        check("rst_state",   32'(State), 32'd0);
        check("rst_cnt",     RetireCnt, 32'd0);
        check("rst_irwrite", 32'(IRWrite), 32'd0);
        check("rst_pcwrite", 32'(PCWrite), 32'd0);
        check("rst_halted",  32'(Halted), 32'd0);

        // R-type ADD
        tick(); Reset = 1'b0; #1;
        check("f_irwrite", 32'(IRWrite), 32'd1);
        check("f_pcwrite", 32'(PCWrite), 32'd1);
        check("f_srcb",    32'(ALUSrcB), 32'd1);
        tick(); #1;
        check("r_dec_state", 32'(State), 32'd1);
        check("r_dec_srcb",  32'(ALUSrcB), 32'd2);
        check("r_dec_ir",    32'(IRWrite), 32'd0);
        tick(); #1;
        check("r_ex_state", 32'(State), 32'd2);
        check("r_ex_rread", 32'(RegRead), 32'd1);
        check("r_ex_srca",  32'(ALUSrcA), 32'd1);
        tick(); #1;
        check("r_wb_state",  32'(State), 32'd4);
        check("r_wb_rwrite", 32'(RegWrite), 32'd1);
        check("r_wb_regdst", 32'(RegDst), 32'd1);
        check("r_wb_cnt",    RetireCnt, 32'd0);

        // LW
        tick(); OPCODE = 6'h20; #1;
        check("lw_f_state", 32'(State), 32'd0);
        check("lw_f_cnt",   RetireCnt, 32'd1);
        tick(); tick(); #1;
        check("lw_ma_state", 32'(State), 32'd5);
        check("lw_ma_srcb",  32'(ALUSrcB), 32'd2);
        tick(); #1;
        check("lw_rd_state", 32'(State), 32'd6);
        check("lw_rd_mdr",   32'(MDRWrite), 32'd1);
        tick(); #1;
        check("lw_wb_state",  32'(State), 32'd7);
        check("lw_wb_m2r",    32'(MemtoReg), 32'd1);
        check("lw_wb_rwrite", 32'(RegWrite), 32'd1);
        check("lw_wb_regdst", 32'(RegDst), 32'd0);

        // Branch 0x31
        tick(); OPCODE = 6'h31; #1;
        check("br_f_cnt", RetireCnt, 32'd2);
        tick(); tick(); #1;
        check("br_state", 32'(State), 32'd9);
        check("br_pcwc",  32'(PCWriteCond), 32'd1);
        check("br_pcsrc", 32'(PCSource), 32'd1);
        check("br_cond",  32'(BranchCond), 32'd1);
        check("br_aluop", 32'(ALUOp), 32'd1);

        // JAL
        tick(); OPCODE = 6'h39; #1;
        check("jal_f_state", 32'(State), 32'd0);
        check("jal_f_cnt",   RetireCnt, 32'd3);
        tick(); tick(); #1;
        check("jal1_state", 32'(State), 32'd11);
        check("jal1_pcw",   32'(PCWrite), 32'd1);
        check("jal1_pcsrc", 32'(PCSource), 32'd2);
        check("jal1_aluop", 32'(ALUOp), 32'd15);
        tick(); #1;
        check("jal2_state",  32'(State), 32'd12);
        check("jal2_rwrite", 32'(RegWrite), 32'd1);
        check("jal2_regdst", 32'(RegDst), 32'd2);

        // I-type ORI 0x13 (zero-extended immediate)
        tick(); OPCODE = 6'h13; #1;
        check("ori_f_cnt", RetireCnt, 32'd4);
        tick(); tick(); #1;
        check("ori_state", 32'(State), 32'd3);
        check("ori_szs",   32'(SZS), 32'd1);
        check("ori_aluop", 32'(ALUOp), 32'd3);
        check("ori_rread", 32'(RegRead), 32'd0);
        tick(); #1;
        check("ori_wb_state",  32'(State), 32'd4);
        check("ori_wb_regdst", 32'(RegDst), 32'd0);

        // Illegal opcode 0x2A
        tick(); OPCODE = 6'h2A; #1;
        check("ill_f_cnt", RetireCnt, 32'd5);
        tick(); #1;
        check("ill_dec_state", 32'(State), 32'd1);
        check("ill_pulse",     32'(IllegalOp), 32'd1);

        // Run=0 holds FETCH with strobes low
        tick(); Run = 1'b0; #1;
        check("ill_back_state", 32'(State), 32'd0);
        check("ill_pulse_end",  32'(IllegalOp), 32'd0);
        check("ill_cnt",        RetireCnt, 32'd6);
        check("hold_irwrite",   32'(IRWrite), 32'd0);
        check("hold_pcwrite",   32'(PCWrite), 32'd0);
        tick(); #1;
        check("hold_state", 32'(State), 32'd0);
        check("hold_cnt",   RetireCnt, 32'd6);

        // Reset in the middle of LW
        Run = 1'b1; OPCODE = 6'h20;
        tick(); tick(); tick(); #1;
        check("mid_rd_state", 32'(State), 32'd6);
        check("mid_rd_mdr",   32'(MDRWrite), 32'd1);
        Reset = 1'b1; #1;
        check("mid_rst_state",  32'(State), 32'd0);
        check("mid_rst_mdr",    32'(MDRWrite), 32'd0);
        check("mid_rst_rwrite", 32'(RegWrite), 32'd0);
        check("mid_rst_cnt",    RetireCnt, 32'd0);
        tick(); #1;
        check("mid_rst_hold_state", 32'(State), 32'd0);
        check("mid_rst_hold_cnt",   RetireCnt, 32'd0);

        // HALT is sticky until Reset
        tick(); Reset = 1'b0; OPCODE = 6'h3F;
        tick(); tick(); #1;
        check("halt_state",  32'(State), 32'd13);
        check("halt_flag",   32'(Halted), 32'd1);
        check("halt_cnt",    RetireCnt, 32'd1);
        repeat (5) tick();
        #1;
        check("halt_hold_state", 32'(State), 32'd13);
        check("halt_hold_flag",  32'(Halted), 32'd1);
        check("halt_hold_cnt",   RetireCnt, 32'd1);
        check("halt_hold_pcw",   32'(PCWrite), 32'd0);
        Reset = 1'b1; #1;
        check("halt_rst_flag",  32'(Halted), 32'd0);
        check("halt_rst_state", 32'(State), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Moore FSM that sequences the multicycle 32-bit datapath. Consumes the 6-bit OPCODE latched in the instruction register and produces every datapath control strobe and mux select once per state. Sits directly upstream of the datapath: its outputs drive the datapath control inputs one-to-one. Also provides halt/illegal-op status and a retired-instruction counter.

Parameters:
CNT_WIDTH, 32, width of retired-instruction counter

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
Run  in  1  1 = allow leaving FETCH; 0 = hold in FETCH with all strobes low
OPCODE  in  6  opcode from instruction register
PCWrite, PCWriteCond, IRWrite, MemWrite, MDRWrite, RegWrite, MemtoReg, RegRead  out  1 each  datapath strobes/selects
PCSource, ALUSrcB, SZS, BranchCond, RegDst  out  2 each  mux selects
ALUSrcA  out  3  ALU A select (000 PC, 001 A, 010 zero)
ALUOp  out  4  ALU function
Halted  out  1  high while in HALT
IllegalOp  out  1  one-cycle pulse on undefined opcode
RetireCnt  out  CNT_WIDTH  instructions completed since reset
State  out  4  current state code (debug)

Behaviour:
- Reset asserted: state=FETCH, all strobes/selects 0, Halted=0, IllegalOp=0, RetireCnt=0. Takes effect immediately, including mid-instruction; a partially executed instruction is abandoned with no further writes.
- Outputs are pure decode of registered state plus OPCODE; no output depends on Run except FETCH gating.
- Unlisted outputs are 0 in every state.
- ALUOp: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLL, 8 SRL, F PASS_A.
- SZS: 00 sign-extend, 01 zero-extend, 10 imm<<16. RegDst: 00 Read1 field, 01 Read3 field, 10 r31.
- Opcodes: 0x00-0x08 R-type (ALUOp=OPCODE[3:0]); 0x10-0x18 I-type (ALUOp=OPCODE[3:0]); 0x1F LUI; 0x20 LW; 0x21 SW; 0x30-0x33 branch (BranchCond=OPCODE[1:0]); 0x38 J; 0x39 JAL; 0x3F HALT; all others illegal.
- FETCH: if Run: IRWrite=1, ALUSrcA=000, ALUSrcB=01, ALUOp=ADD, PCSource=00, PCWrite=1, go DECODE; else stay, strobes low.
- DECODE: ALUSrcA=000, ALUSrcB=10, SZS=00, ALUOp=ADD (branch target PC+1+simm into ALU result reg). Next state by opcode: EXEC_R, EXEC_I, MEM_ADDR, BRANCH, JUMP, JAL1, HALT; illegal -> FETCH with IllegalOp=1 that cycle, counted as retired.
- EXEC_R: RegRead=1, ALUSrcA=001, ALUSrcB=00 -> ALU_WB. EXEC_I: RegRead=0, ALUSrcA=001, ALUSrcB=10, SZS=01 for AND/OR/XOR/NOR else 00; LUI uses ALUSrcA=010, SZS=10, ALUOp=ADD -> ALU_WB.
- ALU_WB: RegWrite=1, MemtoReg=0, RegDst=01 (R-type) or 00 (I-type/LUI) -> FETCH.
- MEM_ADDR: ALUSrcA=001, ALUSrcB=10, SZS=00, ALUOp=ADD -> MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: MDRWrite=1 -> MEM_WB. MEM_WB: RegWrite=1, MemtoReg=1, RegDst=00 -> FETCH. MEM_WR: MemWrite=1 -> FETCH.
- BRANCH: ALUSrcA=001, ALUSrcB=00, ALUOp=SUB, PCWriteCond=1, PCSource=01 -> FETCH.
- JUMP: PCSource=10, PCWrite=1 -> FETCH.
- JAL1: ALUSrcA=000, ALUOp=PASS_A, PCSource=10, PCWrite=1 -> JAL2. JAL2: RegWrite=1, RegDst=10, MemtoReg=0 -> FETCH.
- HALT: Halted=1, all strobes 0; exits only on Reset.
- Cycles per instruction: branch/J 3, R/I/SW/JAL 4, LW 5, illegal 2.
- RetireCnt increments on every transition into FETCH from a non-FETCH state and on entry to HALT; wraps modulo 2^CNT_WIDTH silently.

Decomposition:
- Package cpu_ctrl_pkg: state enum (FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, JAL1, JAL2, HALT), opcode constants, ALUOp codes, SZS/RegDst/ALUSrcA/ALUSrcB/PCSource select codes.
- One sub-module: ctrl_decode, purely combinational state+OPCODE -> control word; FSM register and counter stay in top.

Test Plan:
- Reset mid-LW (in MEM_RD) -> next cycle State=FETCH, MDRWrite=0, RegWrite=0, RetireCnt=0.
- OPCODE=0x00 with Run=1 -> FETCH, DECODE, EXEC_R, ALU_WB; ALU_WB shows RegWrite=1, RegDst=01; RetireCnt 0->1.
- OPCODE=0x20 -> 5 states; MEM_RD MDRWrite=1; MEM_WB MemtoReg=1, RegWrite=1, RegDst=00.
- OPCODE=0x31 -> BRANCH: PCWriteCond=1, PCSource=01, BranchCond=01, ALUOp=1; 3 cycles total.
- OPCODE=0x39 -> JAL1 PCWrite=1, PCSource=10, ALUOp=F; JAL2 RegWrite=1, RegDst=10.
- OPCODE=0x2A -> IllegalOp pulse 1 cycle in DECODE, back to FETCH; Run=0 holds FETCH, IRWrite=0; OPCODE=0x3F -> Halted=1 until Reset.
